midi_msg_parser: RTL and testbench

//  Sequences the raw byte stream from midi_receiver into complete MIDI channel-voice messages.

---
 rtl/midi_msg_parser_pkg.sv | 63 ++++++
 rtl/midi_msg_parser_if.sv | 27 ++
 rtl/midi_msg_parser.sv | 136 +++++++++++++
 tb/tb_midi_msg_parser.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/midi_msg_parser_pkg.sv
// Shared types and constants for the MIDI byte-stream to channel-voice message parser.
package midi_msg_parser_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = 7;
  localparam int unsigned CHAN_W = 4;
  localparam int unsigned ERR_W  = 8;

  typedef enum logic [2:0] {
    NOTE_OFF = 3'd0,
    NOTE_ON  = 3'd1,
    POLY_AT  = 3'd2,
    CC       = 3'd3,
    PROG     = 3'd4,
    CHAN_AT  = 3'd5,
    PITCH    = 3'd6
  } msg_type_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2,
    SYSEX   = 2'd3
  } state_e;

  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_POLY_AT  = 4'hA;
  localparam logic [3:0] ST_CC       = 4'hB;
  localparam logic [3:0] ST_PROG     = 4'hC;
  localparam logic [3:0] ST_CHAN_AT  = 4'hD;
  localparam logic [3:0] ST_PITCH    = 4'hE;

  localparam logic [BYTE_W-1:0] SYSEX_START = 8'hF0;
  localparam logic [BYTE_W-1:0] SYSEX_END   = 8'hF7;
  localparam logic [BYTE_W-1:0] RT_MIN      = 8'hF8;

  typedef struct packed {
    msg_type_e         mtype;
    logic [CHAN_W-1:0] channel;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
  } midi_msg_t;

  // Number of data bytes that follow a channel status byte.
  function automatic logic [1:0] midi_data_len(input logic [BYTE_W-1:0] status);
    if (status[7:4] == ST_PROG || status[7:4] == ST_CHAN_AT) return 2'd1;
    return 2'd2;
  endfunction

  function automatic msg_type_e status_to_type(input logic [3:0] nibble);
    case (nibble)
      ST_NOTE_OFF: return NOTE_OFF;
      ST_NOTE_ON:  return NOTE_ON;
      ST_POLY_AT:  return POLY_AT;
      ST_CC:       return CC;
      ST_PROG:     return PROG;
      ST_CHAN_AT:  return CHAN_AT;
      default:     return PITCH;
    endcase
  endfunction

endpackage

// File: rtl/midi_msg_parser_if.sv
// Byte-in / message-out bundle between midi_receiver, the parser and downstream logic.
interface midi_msg_parser_if;
  import midi_msg_parser_pkg::*;

  logic [BYTE_W-1:0] byte_in;
  logic              byte_valid;
  logic              msg_valid;
  msg_type_e         msg_type;
  logic [CHAN_W-1:0] msg_channel;
  logic [DATA_W-1:0] msg_data1;
  logic [DATA_W-1:0] msg_data2;
  logic              rt_valid;
  logic [BYTE_W-1:0] rt_byte;
  logic [ERR_W-1:0]  err_count;

  modport master (
    output byte_in, byte_valid,
    input  msg_valid, msg_type, msg_channel, msg_data1, msg_data2,
    input  rt_valid, rt_byte, err_count
  );

  modport slave (
    input  byte_in, byte_valid,
    output msg_valid, msg_type, msg_channel, msg_data1, msg_data2,
    output rt_valid, rt_byte, err_count
  );
endinterface

// File: rtl/midi_msg_parser.sv
// Turns a raw MIDI byte stream into registered channel-voice message strobes,
// handling running status, SysEx skipping and interleaved realtime bytes.
module midi_msg_parser
  import midi_msg_parser_pkg::*;
#(
  parameter bit         VEL0_IS_OFF = 1'b1,
  parameter bit         OMNI        = 1'b1,
  parameter logic [3:0] CHANNEL     = 4'd0
) (
  input logic               clk,
  input logic               reset,
  midi_msg_parser_if.slave  bus
);

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] status_q, status_d;
  logic              fresh_q, fresh_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  midi_msg_t         msg_q, msg_d;
  logic              msg_valid_q, msg_valid_d;
  logic              rt_valid_q, rt_valid_d;
  logic [BYTE_W-1:0] rt_byte_q, rt_byte_d;
  logic [ERR_W-1:0]  err_q, err_d;

  logic              emit;
  logic              err_inc;
  logic [DATA_W-1:0] emit_d1;
  logic [DATA_W-1:0] emit_d2;
  msg_type_e         emit_type;

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      status_q    <= '0;
      fresh_q     <= 1'b0;
      data1_q     <= '0;
      msg_q       <= '0;
      msg_valid_q <= 1'b0;
      rt_valid_q  <= 1'b0;
      rt_byte_q   <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      fresh_q     <= fresh_d;
      data1_q     <= data1_d;
      msg_q       <= msg_d;
      msg_valid_q <= msg_valid_d;
      rt_valid_q  <= rt_valid_d;
      rt_byte_q   <= rt_byte_d;
      err_q       <= err_d;
    end
  end

  // Byte classification, next state and message assembly.
  // fresh_q marks a status byte received with no data yet, so a new status
  // arriving then still counts as a dropped partial message.
  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    fresh_d     = fresh_q;
    data1_d     = data1_q;
    msg_d       = msg_q;
    msg_valid_d = 1'b0;
    rt_valid_d  = 1'b0;
    rt_byte_d   = rt_byte_q;
    emit        = 1'b0;
    err_inc     = 1'b0;
    emit_d1     = data1_q;
    emit_d2     = '0;
    emit_type   = NOTE_OFF;

    if (bus.byte_valid) begin
      if (bus.byte_in >= RT_MIN) begin
        rt_valid_d = 1'b1;
        rt_byte_d  = bus.byte_in;
      end else if (bus.byte_in[7] && bus.byte_in < SYSEX_START) begin
        err_inc  = (state_q == WAIT_D2) || (state_q == WAIT_D1 && fresh_q);
        status_d = bus.byte_in;
        fresh_d  = 1'b1;
        state_d  = WAIT_D1;
      end else if (bus.byte_in == SYSEX_START) begin
        status_d = '0;
        fresh_d  = 1'b0;
        state_d  = SYSEX;
      end else if (bus.byte_in[7]) begin
        // SYSEX_END and the remaining system common bytes abandon running status.
        status_d = '0;
        fresh_d  = 1'b0;
        state_d  = IDLE;
      end else begin
        case (state_q)
          IDLE: err_inc = 1'b1;
          WAIT_D1: begin
            data1_d = bus.byte_in[DATA_W-1:0];
            emit_d1 = bus.byte_in[DATA_W-1:0];
            fresh_d = 1'b0;
            if (midi_data_len(status_q) == 2'd1) emit = 1'b1;
            else state_d = WAIT_D2;
          end
          WAIT_D2: begin
            emit    = 1'b1;
            emit_d2 = bus.byte_in[DATA_W-1:0];
            state_d = WAIT_D1;
          end
          default: ;
        endcase
      end
    end

    if (emit) begin
      emit_type = status_to_type(status_q[7:4]);
      if (VEL0_IS_OFF && emit_type == NOTE_ON && emit_d2 == '0) emit_type = NOTE_OFF;
      if (OMNI || status_q[3:0] == CHANNEL) begin
        msg_valid_d   = 1'b1;
        msg_d.mtype   = emit_type;
        msg_d.channel = status_q[3:0];
        msg_d.data1   = emit_d1;
        msg_d.data2   = emit_d2;
      end
    end

    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  assign bus.msg_valid   = msg_valid_q;
  assign bus.msg_type    = msg_q.mtype;
  assign bus.msg_channel = msg_q.channel;
  assign bus.msg_data1   = msg_q.data1;
  assign bus.msg_data2   = msg_q.data2;
  assign bus.rt_valid    = rt_valid_q;
  assign bus.rt_byte     = rt_byte_q;
  assign bus.err_count   = err_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed self-checking bench for midi_msg_parser (omni instance plus a channel-3 filtered instance).
module tb_midi_msg_parser;
  import midi_msg_parser_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  midi_msg_parser_if bus ();
  midi_msg_parser_if bus_f ();

  midi_msg_parser #(.VEL0_IS_OFF(1'b1), .OMNI(1'b1), .CHANNEL(4'd0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  midi_msg_parser #(.VEL0_IS_OFF(1'b1), .OMNI(1'b0), .CHANNEL(4'd3)) dut_f (
    .clk(clk), .reset(reset), .bus(bus_f)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one byte for one cycle; returns at the next falling edge where its effect is visible.
  task automatic send(input logic [7:0] b);
    bus.byte_in      = b;
    bus.byte_valid   = 1'b1;
    bus_f.byte_in    = b;
    bus_f.byte_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    bus.byte_valid   = 1'b0;
    bus_f.byte_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_msg(input string tag, input logic [2:0] t, input logic [3:0] ch,
                         input logic [6:0] d1, input logic [6:0] d2);
    chk({tag, "_valid"}, 8'(bus.msg_valid), 8'h01);
    chk({tag, "_type"},  8'(bus.msg_type), 8'(t));
    chk({tag, "_chan"},  8'(bus.msg_channel), 8'(ch));
    chk({tag, "_d1"},    8'(bus.msg_data1), 8'(d1));
    chk({tag, "_d2"},    8'(bus.msg_data2), 8'(d2));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_msg_valid"}, 8'(bus.msg_valid), 8'h00);
    chk({tag, "_msg_type"},  8'(bus.msg_type), 8'h00);
    chk({tag, "_chan"},      8'(bus.msg_channel), 8'h00);
    chk({tag, "_d1"},        8'(bus.msg_data1), 8'h00);
    chk({tag, "_d2"},        8'(bus.msg_data2), 8'h00);
    chk({tag, "_rt_valid"},  8'(bus.rt_valid), 8'h00);
    chk({tag, "_rt_byte"},   bus.rt_byte, 8'h00);
    chk({tag, "_err"},       bus.err_count, 8'h00);
  endtask

  initial begin
    reset            = 1'b0;
    bus.byte_in      = 8'h00;
    bus.byte_valid   = 1'b0;
    bus_f.byte_in    = 8'h00;
    bus_f.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // 90 3C 64: single NOTE_ON, strobe one cycle after the last byte
    send(8'h90); chk("t1_b1_mv", 8'(bus.msg_valid), 8'h00);
    send(8'h3C); chk("t1_b2_mv", 8'(bus.msg_valid), 8'h00);
    send(8'h64); chk_msg("t1", 3'd1, 4'd0, 7'h3C, 7'h64);
    idle();      chk("t1_strobe_len", 8'(bus.msg_valid), 8'h00);
    chk("t1_hold_d1", 8'(bus.msg_data1), 8'h3C);

    // 91 3C 64 3E 00: running status, velocity-0 NOTE_ON reported as NOTE_OFF
    send(8'h91); send(8'h3C);
    send(8'h64); chk_msg("t2a", 3'd1, 4'd1, 7'h3C, 7'h64);
    send(8'h3E); chk("t2_mid_mv", 8'(bus.msg_valid), 8'h00);
    send(8'h00); chk_msg("t2b", 3'd0, 4'd1, 7'h3E, 7'h00);

    // C5 07 08: two PROG messages under running status
    send(8'hC5); chk("t3_st_mv", 8'(bus.msg_valid), 8'h00);
    send(8'h07); chk_msg("t3a", 3'd4, 4'd5, 7'h07, 7'h00);
    send(8'h08); chk_msg("t3b", 3'd4, 4'd5, 7'h08, 7'h00);

    // 90 3C F8 64: realtime interleaves without disturbing the message
    send(8'h90); send(8'h3C);
    send(8'hF8);
    chk("t4_rt_valid", 8'(bus.rt_valid), 8'h01);
    chk("t4_rt_byte", bus.rt_byte, 8'hF8);
    chk("t4_rt_mv", 8'(bus.msg_valid), 8'h00);
    send(8'h64); chk_msg("t4", 3'd1, 4'd0, 7'h3C, 7'h64);
    chk("t4_rt_clr", 8'(bus.rt_valid), 8'h00);
    chk("t4_err", bus.err_count, 8'h00);

    // Pitch bend, then channel filtering on the OMNI=0 / CHANNEL=3 instance
    send(8'hE2); send(8'h01);
    send(8'h40); chk_msg("pitch", 3'd6, 4'd2, 7'h01, 7'h40);
    send(8'hB3); send(8'h10);
    send(8'h20);
    chk("filt_ch3_mv", 8'(bus_f.msg_valid), 8'h01);
    chk("filt_ch3_type", 8'(bus_f.msg_type), 8'h03);
    chk("filt_ch3_chan", 8'(bus_f.msg_channel), 8'h03);
    chk("filt_ch3_d2", 8'(bus_f.msg_data2), 8'h20);
    send(8'hB4); send(8'h11);
    send(8'h22);
    chk_msg("omni_ch4", 3'd3, 4'd4, 7'h11, 7'h22);
    chk("filt_ch4_mv", 8'(bus_f.msg_valid), 8'h00);
    chk("filt_ch4_hold", 8'(bus_f.msg_data1), 8'h10);
    chk("filt_err", bus_f.err_count, 8'h00);

    // F0 01 02 F7 40: SysEx data silent, trailing data with no running status is an error
    send(8'hF0); send(8'h01); send(8'h02); send(8'hF7);
    chk("t5_mv", 8'(bus.msg_valid), 8'h00);
    chk("t5_err_pre", bus.err_count, 8'h00);
    send(8'h40);
    chk("t5_mv2", 8'(bus.msg_valid), 8'h00);
    chk("t5_err", bus.err_count, 8'h01);
    idle();

    // Fresh reset, then 90 3C 80 40 00: partial message dropped by new status
    reset = 1'b0;
    @(negedge clk);
    chk_zero("reset2");
    reset = 1'b1;
    @(negedge clk);
    send(8'h90); send(8'h3C);
    send(8'h80); chk("t6_err", bus.err_count, 8'h01);
    chk("t6_drop_mv", 8'(bus.msg_valid), 8'h00);
    send(8'h40);
    send(8'h00); chk_msg("t6", 3'd0, 4'd0, 7'h40, 7'h00);

    // Asynchronous reset in the middle of a message
    send(8'h90); send(8'h3C);
    bus.byte_valid   = 1'b0;
    bus_f.byte_valid = 1'b0;
    #2 reset = 1'b0;
    #1 chk_zero("async_rst");
    reset = 1'b1;
    @(negedge clk);

    // Running status cleared by reset: the pending data byte is now an error
    send(8'h64);
    chk("post_rst_mv", 8'(bus.msg_valid), 8'h00);
    chk("post_rst_err", bus.err_count, 8'h01);

    // System common mid-message clears running status
    send(8'h90); send(8'hF3);
    send(8'h40);
    chk("syscom_mv", 8'(bus.msg_valid), 8'h00);
    chk("syscom_err", bus.err_count, 8'h02);

    // Error counter saturation
    for (int i = 0; i < 300; i++) send(8'h11);
    idle();
    chk("err_sat", bus.err_count, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
